// File: rtl/div_issue_if.sv
// Signal bundle between div_issue_unit and its surroundings: the request and response
// handshakes, the drive into the divider control unit and the divider result buses.
interface div_issue_if;
    logic              req_valid;
    logic              req_ready;
    logic signed [7:0] req_dividend;
    logic signed [7:0] req_divisor;
    logic              begin_op;
    logic [1:0]        op_code;
    logic signed [7:0] inbus;
    logic              q_strobe;
    logic              r_strobe;
    logic              end_op;
    logic signed [7:0] outbus1;
    logic signed [7:0] outbus2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_quotient;
    logic [7:0]        rsp_remainder;
    logic              rsp_div_zero;
    logic              rsp_timeout;
    logic              busy;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        input  q_strobe, r_strobe, end_op, outbus1, outbus2,
        input  rsp_ready,
        output req_ready, begin_op, op_code, inbus,
        output rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        output q_strobe, r_strobe, end_op, outbus1, outbus2,
        output rsp_ready,
        input  req_ready, begin_op, op_code, inbus,
        input  rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero, rsp_timeout, busy
    );
endinterface

// File: rtl/div_issue_unit.sv
// Sequences one divide request into a multi-cycle divider: loads dividend and divisor
// over inbus, collects strobed quotient/remainder and returns them on a response handshake.
module div_issue_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [1:0]  DIV_OPCODE     = 2'b11
) (
    input logic        clk,
    input logic        rst,
    div_issue_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, LOAD_M0, LOAD_M1, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic signed [7:0] dvd_q, dvd_d;
    logic signed [7:0] dvs_q, dvs_d;
    logic [7:0]        quot_q, quot_d;
    logic [7:0]        rem_q, rem_d;
    logic              dz_q, dz_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_ready_w;
    logic              begin_op_w;
    logic [1:0]        op_code_w;
    logic signed [7:0] inbus_w;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dz_d        = dz_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        req_ready_w = 1'b0;
        begin_op_w  = 1'b0;
        op_code_w   = 2'b00;
        inbus_w     = '0;
        case (state_q)
            IDLE: begin
                req_ready_w = 1'b1;
                if (bus.req_valid) begin
                    dvd_d  = bus.req_dividend;
                    dvs_d  = bus.req_divisor;
                    quot_d = '0;
                    rem_d  = '0;
                    dz_d   = 1'b0;
                    to_d   = 1'b0;
                    // A zero divisor never reaches the divider; answer immediately.
                    if (bus.req_divisor == '0) begin
                        quot_d  = 8'hFF;
                        rem_d   = bus.req_dividend;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                begin_op_w = 1'b1;
                op_code_w  = DIV_OPCODE;
                inbus_w    = dvd_q;
                state_d    = LOAD_M0;
            end
            LOAD_M0: begin
                op_code_w = DIV_OPCODE;
                inbus_w   = dvs_q;
                state_d   = LOAD_M1;
            end
            LOAD_M1: begin
                op_code_w = DIV_OPCODE;
                inbus_w   = dvs_q;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                op_code_w = DIV_OPCODE;
                cnt_d     = cnt_q + CNT_W'(1);
                if (bus.q_strobe) quot_d = bus.outbus1;
                if (bus.r_strobe) rem_d  = bus.outbus2;
                // end_op on the final allowed cycle still wins over the timeout.
                if (bus.end_op) begin
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    quot_d  = '0;
                    rem_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        dvs_q <= dvs_d;
    end

    // Outputs are forced low for the whole time rst is high, not just after its first edge.
    assign bus.req_ready     = req_ready_w & ~rst;
    assign bus.begin_op      = begin_op_w & ~rst;
    assign bus.op_code       = rst ? 2'b00 : op_code_w;
    assign bus.inbus         = rst ? '0 : inbus_w;
    assign bus.rsp_valid     = (state_q == RESP) & ~rst;
    assign bus.rsp_quotient  = rst ? '0 : quot_q;
    assign bus.rsp_remainder = rst ? '0 : rem_q;
    assign bus.rsp_div_zero  = dz_q & ~rst;
    assign bus.rsp_timeout   = to_q & ~rst;
    assign bus.busy          = (state_q != IDLE) & ~rst;
endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit; expected responses go into a queue and a monitor
// compares them at each response handshake.
module tb_div_issue_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       to;
    } rsp_t;

    rsp_t exp_q[$];

    div_issue_if ifc ();

    div_issue_unit #(.TIMEOUT_CYCLES(4), .DIV_OPCODE(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected entry per completed response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && ifc.rsp_valid && ifc.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got q=%0h r=%0h, expected no response",
                         ifc.rsp_quotient, ifc.rsp_remainder);
            end else begin
                e = exp_q.pop_front();
                check("rsp_quotient",  ifc.rsp_quotient,        e.q);
                check("rsp_remainder", ifc.rsp_remainder,       e.r);
                check("rsp_div_zero",  8'(ifc.rsp_div_zero),    8'(e.dz));
                check("rsp_timeout",   8'(ifc.rsp_timeout),     8'(e.to));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 in IDLE; returns at posedge+1 in the cycle after accept.
    task automatic do_req(input logic [7:0] dvd, input logic [7:0] dvs);
        ifc.req_valid    = 1'b1;
        ifc.req_dividend = dvd;
        ifc.req_divisor  = dvs;
        @(negedge clk);
        check("req_ready_idle", 8'(ifc.req_ready), 8'd1);
        tick();
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!ifc.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", 8'(ifc.rsp_valid), 8'd1);
    endtask

    task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                           input logic [7:0] q, input logic [7:0] r, input bit same);
        exp_q.push_back('{q, r, 1'b0, 1'b0});
        do_req(dvd, dvs);
        @(negedge clk);
        check("begin_op_issue", 8'(ifc.begin_op), 8'd1);
        check("inbus_issue",    ifc.inbus,        dvd);
        check("op_code_issue",  8'(ifc.op_code),  8'd3);
        tick();
        @(negedge clk);
        check("begin_op_m0", 8'(ifc.begin_op), 8'd0);
        check("inbus_m0",    ifc.inbus,        dvs);
        tick();
        @(negedge clk);
        check("inbus_m1", ifc.inbus, dvs);
        tick();
        if (same) begin
            // Earlier captures must be overwritten by the final one.
            ifc.q_strobe = 1'b1; ifc.outbus1 = ~q;
            ifc.r_strobe = 1'b1; ifc.outbus2 = ~r;
            tick();
            ifc.outbus1 = q; ifc.outbus2 = r; ifc.end_op = 1'b1;
        end else begin
            ifc.q_strobe = 1'b1; ifc.outbus1 = q;
            tick();
            ifc.q_strobe = 1'b0; ifc.outbus1 = 8'h5A;
            ifc.r_strobe = 1'b1; ifc.outbus2 = r;
            tick();
            ifc.r_strobe = 1'b0; ifc.outbus2 = 8'hA5;
            ifc.end_op   = 1'b1;
        end
        @(negedge clk);
        check("inbus_wait",   ifc.inbus,       8'd0);
        check("op_code_wait", 8'(ifc.op_code), 8'd3);
        tick();
        ifc.q_strobe = 1'b0; ifc.r_strobe = 1'b0; ifc.end_op = 1'b0;
        ifc.outbus1 = 8'h33; ifc.outbus2 = 8'h44;
        wait_rsp();
        tick();
    endtask

    initial begin
        ifc.req_valid = 1'b0; ifc.req_dividend = '0; ifc.req_divisor = '0;
        ifc.q_strobe = 1'b0; ifc.r_strobe = 1'b0; ifc.end_op = 1'b0;
        ifc.outbus1 = '0; ifc.outbus2 = '0; ifc.rsp_ready = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_req_ready", 8'(ifc.req_ready), 8'd0);
        check("rst_busy",      8'(ifc.busy),      8'd0);
        check("rst_rsp_valid", 8'(ifc.rsp_valid), 8'd0);
        check("rst_begin_op",  8'(ifc.begin_op),  8'd0);
        check("rst_inbus",     ifc.inbus,         8'd0);
        check("rst_op_code",   8'(ifc.op_code),   8'd0);
        check("rst_quotient",  ifc.rsp_quotient,  8'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", 8'(ifc.req_ready), 8'd1);
        tick();

        // 100 / 7 with separate strobes
        run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        // Zero divisor: response one cycle after accept, no begin_op
        exp_q.push_back('{8'hFF, 8'hF6, 1'b1, 1'b0});
        do_req(8'hF6, 8'h00);
        @(negedge clk);
        check("dz_rsp_latency", 8'(ifc.rsp_valid), 8'd1);
        check("dz_begin_op",    8'(ifc.begin_op),  8'd0);
        check("dz_op_code",     8'(ifc.op_code),   8'd0);
        tick();

        // Timeout after exactly 4 WAIT cycles; an earlier capture is discarded
        exp_q.push_back('{8'h00, 8'h00, 1'b0, 1'b1});
        do_req(8'd5, 8'd3);
        tick(); tick(); tick();
        ifc.q_strobe = 1'b1; ifc.outbus1 = 8'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_not_yet", 8'(ifc.rsp_valid), 8'd0);
            tick();
            ifc.q_strobe = 1'b0;
        end
        @(negedge clk);
        check("to_rsp_valid", 8'(ifc.rsp_valid), 8'd1);
        tick();

        // Response back-pressure with a competing request; most-negative dividend
        ifc.rsp_ready = 1'b0;
        exp_q.push_back('{8'hFF, 8'h80, 1'b1, 1'b0});
        do_req(8'h80, 8'h00);
        ifc.req_valid = 1'b1; ifc.req_dividend = 8'd1; ifc.req_divisor = 8'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 8'(ifc.rsp_valid),    8'd1);
            check("hold_quotient",  ifc.rsp_quotient,     8'hFF);
            check("hold_remainder", ifc.rsp_remainder,    8'h80);
            check("hold_div_zero",  8'(ifc.rsp_div_zero), 8'd1);
            check("hold_req_ready", 8'(ifc.req_ready),    8'd0);
            check("hold_begin_op",  8'(ifc.begin_op),     8'd0);
            tick();
        end
        ifc.req_valid = 1'b0;
        ifc.rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("after_hold_idle", 8'(ifc.req_ready), 8'd1);
        check("after_hold_busy", 8'(ifc.busy),      8'd0);
        tick();

        // Most-negative operands with same-cycle strobes and end_op
        run_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b1);

        // Reset while loading the divisor aborts with no response
        do_req(8'd20, 8'd3);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_inbus",     ifc.inbus,         8'd0);
        check("midrst_op_code",   8'(ifc.op_code),   8'd0);
        check("midrst_busy",      8'(ifc.busy),      8'd0);
        check("midrst_req_ready", 8'(ifc.req_ready), 8'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_req_ready", 8'(ifc.req_ready), 8'd1);
        check("postrst_rsp_valid", 8'(ifc.rsp_valid), 8'd0);
        tick();
        run_div(8'd20, 8'd3, 8'd6, 8'd2, 1'b0);

        // Divider signals while IDLE are ignored
        ifc.q_strobe = 1'b1; ifc.r_strobe = 1'b1; ifc.end_op = 1'b1;
        ifc.outbus1 = 8'd55; ifc.outbus2 = 8'd66;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_req_ready", 8'(ifc.req_ready), 8'd1);
            check("idle_busy",      8'(ifc.busy),      8'd0);
            check("idle_rsp_valid", 8'(ifc.rsp_valid), 8'd0);
            tick();
        end
        ifc.q_strobe = 1'b0; ifc.r_strobe = 1'b0; ifc.end_op = 1'b0;
        @(negedge clk);
        check("idle_quotient",  ifc.rsp_quotient,  8'd6);
        check("idle_remainder", ifc.rsp_remainder, 8'd2);
        tick(); tick();

        check("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_issue_unit.md
DIV_ISSUE_UNIT -- requirements
Module: div_issue_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the maximum number of WAIT cycles allowed before the operation aborts.
REQ-002 SHALL have parameter DIV_OPCODE, default 2'b11: the op_code value driven to the control unit.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: the reset, synchronous and active-high.
REQ-005 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_dividend (in, 8, signed) and req_divisor (in, 8, signed): the request handshake.
REQ-006 SHALL have ports begin_op (out, 1), op_code (out, 2) and inbus (out, 8, signed): the drive into the divider and its control unit.
REQ-007 SHALL have ports q_strobe (in, 1), r_strobe (in, 1) and end_op (in, 1): control-unit ctrl_sig[12], ctrl_sig[13] and end_op respectively.
REQ-008 SHALL have ports outbus1 (in, 8, signed) and outbus2 (in, 8, signed): the divider quotient and remainder buses.
REQ-009 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_quotient (out, 8), rsp_remainder (out, 8), rsp_div_zero (out, 1) and rsp_timeout (out, 1): the response handshake.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-011 SHALL implement the states IDLE, ISSUE, LOAD_M0, LOAD_M1, WAIT and RESP.
REQ-012 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid&&req_ready at a clock edge.
REQ-013 SHALL, on accept, register the dividend and divisor and clear the quotient, remainder, div_zero and timeout result registers.
REQ-014 SHALL, on accept with req_divisor==0, go to RESP with quotient=8'hFF, remainder=dividend and div_zero=1, and never assert begin_op.
REQ-015 SHALL, on accept with a nonzero divisor, go to ISSUE.
REQ-016 SHALL, in ISSUE (one cycle), drive begin_op=1 and inbus=dividend, then go to LOAD_M0.
REQ-017 SHALL, in LOAD_M0 and in LOAD_M1 (one cycle each), drive inbus=divisor, then go to LOAD_M1 and WAIT respectively.
REQ-018 SHALL drive inbus=0 in every state other than ISSUE, LOAD_M0 and LOAD_M1.
REQ-019 SHALL drive op_code=DIV_OPCODE in ISSUE through WAIT and 2'b00 otherwise.
REQ-020 SHALL, in WAIT, capture outbus1 into the quotient register on any cycle with q_strobe=1; last capture wins.
REQ-021 SHALL, in WAIT, capture outbus2 into the remainder register on any cycle with r_strobe=1; last capture wins.
REQ-022 SHALL, in WAIT, go to RESP on end_op=1; strobes asserted in that same cycle are still captured.
REQ-023 SHALL keep a WAIT cycle counter that clears on entry to WAIT; if the counter reaches TIMEOUT_CYCLES with end_op=0, SHALL go to RESP with timeout=1, quotient=0 and remainder=0.
REQ-024 SHALL ignore q_strobe, r_strobe and end_op in every state other than WAIT.
REQ-025 SHALL drive rsp_valid=1 only in RESP, with rsp_* holding stable until the handshake.
REQ-026 SHALL go from RESP to IDLE on rsp_ready=1; a new request is accepted no earlier than the cycle after.
REQ-027 SHALL give accept-to-begin_op latency of exactly one cycle for a nonzero divisor.
REQ-028 SHALL give accept-to-rsp_valid latency of exactly one cycle for a zero divisor.
REQ-029 SHALL behave the same for the most-negative operands 8'h80 as for any other value; the unit never performs arithmetic on operands.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, enter IDLE and clear all result registers and the WAIT counter.
REQ-031 SHALL, while in reset, hold begin_op, inbus, op_code, rsp_valid, rsp_div_zero, rsp_timeout and busy at 0, rsp_quotient and rsp_remainder at 0, and req_ready at 0.
REQ-032 SHALL, on reset mid-operation (any state), abort with no response produced; the integrator ties divider rst_b = ~rst.
REQ-033 SHALL assert req_ready=1 on the first cycle after rst deasserts.

Verification
REQ-034 SHALL be covered by: dividend 8'd100, divisor 8'd7, q_strobe with outbus1=14, r_strobe with outbus2=2, then end_op -> begin_op one cycle after accept; inbus 100,7,7; rsp 14/2 with flags 0.
REQ-035 SHALL be covered by: divisor 0, dividend 8'hF6 -> rsp_valid on the next cycle; quotient 8'hFF, remainder 8'hF6, div_zero=1; begin_op never asserted.
REQ-036 SHALL be covered by: end_op withheld with TIMEOUT_CYCLES=4 -> RESP after 4 WAIT cycles; timeout=1, quotient and remainder 0.
REQ-037 SHALL be covered by: rsp_ready held 0 for 10 cycles -> rsp_* stable and req_ready=0 throughout; a request presented meanwhile is not accepted.
REQ-038 SHALL be covered by: rst=1 in LOAD_M0 -> next cycle IDLE with all outputs 0; a following request completes normally.
REQ-039 SHALL be covered by: q_strobe, r_strobe and end_op pulsed while IDLE -> no state change and results unchanged.
